// File: rtl/pong_pkg.sv
// Shared playfield geometry, direction type and coordinate helper for the pong ball engine.
package pong_pkg;

  localparam int FIELD_W = 32;
  localparam int FIELD_H = 32;

  localparam logic [4:0] X_CENTER    = 5'd16;
  localparam logic [4:0] X_LEFT_HIT  = 5'd1;
  localparam logic [4:0] X_RIGHT_HIT = 5'd30;
  localparam logic [4:0] X_OUT_LEFT  = 5'd0;
  localparam logic [4:0] X_OUT_RIGHT = 5'(FIELD_W - 1);
  localparam logic [4:0] Y_TOP       = 5'd0;
  localparam logic [4:0] Y_BOTTOM    = 5'(FIELD_H - 1);

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  function automatic logic [4:0] stepCoord(input logic [4:0] v, input dir_t d);
    return (d == DIR_POS) ? v + 5'd1 : v - 5'd1;
  endfunction

endpackage

// File: rtl/pong_step_timer.sv
// Speed-to-period divider: emits a one-cycle step pulse every (16 - speed) * STEP_UNIT ticks.
module pong_step_timer
  import pong_pkg::*;
#(
  parameter int STEP_UNIT = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] speed_i,
  output logic       step_o
);

  localparam int CNT_W = $clog2(16 * STEP_UNIT) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] periodM1;
  logic             terminal;

  // The period is recomputed every cycle so a speed change lands at the next compare.
  assign periodM1 = CNT_W'((16 - int'(speed_i)) * STEP_UNIT - 1);
  assign terminal = (cnt_q >= periodM1);
  assign step_o   = (speed_i != 4'd0) && terminal;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (speed_i == 4'd0 || terminal) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pong_ball.sv
// Pong ball physics: position, wall/paddle bounces and sticky out flags.
// Define BALL_JITTER_EN to redraw dy from entropy[0] on every paddle bounce.
module pong_ball
  import pong_pkg::*;
#(
  parameter int STEP_UNIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  entropy,
  input  logic [3:0]  speed,
  input  logic [31:0] lpaddle,
  input  logic [31:0] rpaddle,
  output logic [4:0]  x,
  output logic [4:0]  y,
  output logic        out_left,
  output logic        out_right
);

`ifdef BALL_JITTER_EN
  localparam bit JITTER = 1'b1;
`else
  localparam bit JITTER = 1'b0;
`endif

  logic [4:0] x_q, x_d, y_q, y_d;
  dir_t       dx_q, dx_d, dy_q, dy_d;
  logic       outLeft_q, outLeft_d, outRight_q, outRight_d;
  logic       step, moveEn, paddleHit;

  pong_step_timer #(.STEP_UNIT(STEP_UNIT)) uTimer (
    .clk_i  (clk),
    .rst_ni (reset),
    .speed_i(speed),
    .step_o (step)
  );

  assign moveEn = step && !outLeft_q && !outRight_q;

  // Directions come from the pre-move position; walls are applied last so they override jitter.
  always_comb begin
    dx_d       = dx_q;
    dy_d       = dy_q;
    x_d        = x_q;
    y_d        = y_q;
    outLeft_d  = outLeft_q;
    outRight_d = outRight_q;
    paddleHit  = 1'b0;
    if (moveEn) begin
      if (x_q == X_LEFT_HIT && dx_q == DIR_NEG && lpaddle[y_q]) begin
        dx_d      = DIR_POS;
        paddleHit = 1'b1;
      end
      if (x_q == X_RIGHT_HIT && dx_q == DIR_POS && rpaddle[y_q]) begin
        dx_d      = DIR_NEG;
        paddleHit = 1'b1;
      end
      if (JITTER && paddleHit) begin
        dy_d = dir_t'(entropy[0]);
      end
      if (y_q == Y_TOP) begin
        dy_d = DIR_POS;
      end else if (y_q == Y_BOTTOM) begin
        dy_d = DIR_NEG;
      end
      x_d = stepCoord(x_q, dx_d);
      y_d = stepCoord(y_q, dy_d);
      if (x_d == X_OUT_LEFT) begin
        outLeft_d = 1'b1;
      end
      if (x_d == X_OUT_RIGHT) begin
        outRight_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q        <= X_CENTER;
      y_q        <= entropy;
      dx_q       <= dir_t'(entropy[0]);
      dy_q       <= dir_t'(entropy[1]);
      outLeft_q  <= 1'b0;
      outRight_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      outLeft_q  <= outLeft_d;
      outRight_q <= outRight_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign out_left  = outLeft_q;
  assign out_right = outRight_q;

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: serve, freeze, step timing, wall/paddle bounces, out flags.
module tb_pong_ball;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  entropy = '0;
  logic [3:0]  speed = '0;
  logic [31:0] lpaddle = '0;
  logic [31:0] rpaddle = '0;
  logic [4:0]  x, y;
  logic        out_left, out_right;

  int testCount = 0;
  int failCount = 0;

  pong_ball #(.STEP_UNIT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .entropy  (entropy),
    .speed    (speed),
    .lpaddle  (lpaddle),
    .rpaddle  (rpaddle),
    .x        (x),
    .y        (y),
    .out_left (out_left),
    .out_right(out_right)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [4:0] e);
    @(negedge clk);
    reset   = 1'b0;
    entropy = e;
    @(negedge clk);
    reset   = 1'b1;
  endtask

  task automatic checkBall(input string tag, input int ex, input int ey, input bit eL, input bit eR);
    checkOutput({tag, ".x"}, 32'(x), 32'(ex));
    checkOutput({tag, ".y"}, 32'(y), 32'(ey));
    checkOutput({tag, ".outL"}, 32'(out_left), 32'(eL));
    checkOutput({tag, ".outR"}, 32'(out_right), 32'(eR));
  endtask

  initial begin
    // Serve from row 23 heading right/down, frozen at speed 0.
    speed = 4'd0;
    applyStimulus(5'b10111);
    checkBall("reset", 16, 23, 0, 0);
    tick(500);
    checkBall("frozen", 16, 23, 0, 0);

    // Fastest speed: one move every 8 ticks.
    speed = 4'd15;
    tick(7);
    checkBall("preStep", 16, 23, 0, 0);
    tick(1);
    checkBall("step1", 17, 24, 0, 0);
    tick(8);
    checkBall("step2", 18, 25, 0, 0);
    tick(48);
    checkBall("atBottom", 24, 31, 0, 0);
    tick(8);
    checkBall("bottomBounce", 25, 30, 0, 0);
    tick(8);
    checkBall("afterBottom", 26, 29, 0, 0);
    tick(40);
    checkBall("outRightNoPaddle", 31, 24, 0, 1);

    // Top wall then full left paddle.
    lpaddle = 32'hFFFF_FFFF;
    applyStimulus(5'b00100);
    tick(32);
    checkBall("atTop", 12, 0, 0, 0);
    tick(8);
    checkBall("topBounce", 11, 1, 0, 0);
    tick(80);
    checkBall("atLeftHit", 1, 11, 0, 0);
    tick(8);
    checkBall("leftBounce", 2, 12, 0, 0);
    tick(8);
    checkBall("afterLeft", 3, 13, 0, 0);
    speed = 4'd0;
    tick(100);
    checkBall("midFreeze", 3, 13, 0, 0);
    speed = 4'd15;

    // No left paddle: ball exits and stays put until re-served.
    lpaddle = '0;
    applyStimulus(5'b00000);
    tick(120);
    checkBall("nearLeft", 1, 15, 0, 0);
    tick(8);
    checkBall("outLeft", 0, 16, 1, 0);
    tick(1000);
    checkBall("outLeftHeld", 0, 16, 1, 0);
    applyStimulus(5'b00000);
    checkBall("reserve", 16, 0, 0, 0);

    // Right paddle only on row 10; ball arrives on row 11 and escapes.
    rpaddle = 32'h0000_0400;
    applyStimulus(5'b11001);
    tick(112);
    checkBall("atRightHit", 30, 11, 0, 0);
    tick(8);
    checkBall("rightMiss", 31, 10, 0, 1);

    // Same trajectory with the paddle moved onto row 11.
    rpaddle = 32'h0000_0800;
    applyStimulus(5'b11001);
    tick(112);
    checkBall("atRightHit2", 30, 11, 0, 0);
    tick(8);
    checkBall("rightBounce", 29, 10, 0, 0);
    tick(8);
    checkBall("afterRight", 28, 9, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/pong_ball.md
Name: pong_ball

Overview:
- Ball physics engine for the 32x32 pong playfield, clocked by the 1 kHz game tick.
- Holds ball position and direction, and steps the ball at a rate set by `speed`.
- Bounces the ball off the top and bottom walls and off the paddles.
- Flags when the ball leaves the field on the left or right side. The game/score controller drives its reset and speed.

Parameters:
- STEP_UNIT, 8, game ticks per speed unit; the ball moves once every (16 - speed) * STEP_UNIT ticks.

Ports:
- clk  input  1  game clock (1 kHz tick).
- reset  input  1  synchronous, active-low reset; also serves as the re-serve/centre command.
- entropy  input  5  random bits sampled at reset for serve row and direction.
- speed  input  4  0 = ball frozen; 1..15 = increasing ball speed.
- lpaddle  input  32  left paddle bitmap; bit i set means the paddle covers row i at column 0.
- rpaddle  input  32  right paddle bitmap; bit i set means the paddle covers row i at column 31.
- x  output  5  ball column, 0..31.
- y  output  5  ball row, 0..31.
- out_left  output  1  ball has left the field on the left side (sticky).
- out_right  output  1  ball has left the field on the right side (sticky).

Behaviour:
- Reset (reset==0 at a clk edge):
  - x=16, y=entropy.
  - dx=right if entropy[0] else left; dy=down if entropy[1] else up.
  - Step counter=0; out_left=out_right=0.
  - Reset has priority over everything, including mid-step or while an out flag is set.
- Freeze:
  - speed==0 → counter held at 0; x, y, dx, dy and the out flags hold.
  - If out_left or out_right is 1 → the ball no longer moves until the next reset.
- Step timing:
  - When speed!=0, the counter increments every clk.
  - When counter >= (16-speed)*STEP_UNIT - 1, the counter clears and one move step executes that cycle.
  - Speed changes take effect at the next comparison; the counter is not cleared.
- Move step: new direction is computed from the current (pre-move) position; position updates the same cycle with the new direction.
  - Left paddle hit: x==1, dx=left, lpaddle[y]==1 → dx=right.
  - Right paddle hit: x==30, dx=right, rpaddle[y]==1 → dx=left.
  - Top wall: y==0 with dy=up → dy=down.
  - Bottom wall: y==31 with dy=down → dy=up.
  - Walls and paddles are evaluated independently, so a corner hit flips both directions in one step.
  - Then x += ±1 and y += ±1, always diagonal, 5-bit. Wrap cannot occur because of the bounce rules.
- Out detection:
  - If the new x==0 → out_left=1 from the next cycle onward.
  - If the new x==31 → out_right=1.
  - Both flags stay high until reset; they are never both high.
- Outputs: x and y are registered; out flags are registered; no combinational path from the inputs to the outputs.

Optional Feature:
- BALL_JITTER_EN defined:
  - On every paddle bounce, dy is redrawn from entropy[0] (1=down, 0=up) instead of being kept.
  - The wall rule still overrides: at y==0 dy=down, at y==31 dy=up.
- Undefined: dy is changed only by the wall rules.

Decomposition:
- Shared package pong_pkg holds:
  - FIELD_W=32 and FIELD_H=32.
  - X_CENTER=16.
  - X_LEFT_HIT=1 and X_RIGHT_HIT=30.
  - A dir_t typedef (1 bit: 0=neg, 1=pos).
- One natural sub-module: pong_step_timer, the speed-to-period counter that produces a one-cycle step pulse.

Test Plan:
- Reset with entropy=5'b10111 → x=16, y=23, dx=right, dy=down, out flags 0. Hold speed=0 for 500 clks → x and y unchanged.
- speed=15, STEP_UNIT=8 → first move after exactly 8 clks (x=17, y=24). The next move comes 8 clks later.
- Ball at y=31 moving down, speed=15 → next step gives y=30 and dy=up. Likewise y=0 up → y=1.
- lpaddle=32'hFFFF_FFFF, ball approaching left → at x=1 it bounces to x=2, and out_left stays 0.
- lpaddle=0, ball moving left → x reaches 0, out_left=1 the cycle after, ball stays fixed for 1000 clks. Then reset low for one clk → out_left=0 and x=16.
- rpaddle covering only row 10, ball at x=30 with y=11 → x=31 and out_right=1. Repeat with y=10 → bounce to x=29.
